// File: rtl/submod_rr_merge.sv
// Multi-lane merge: each input lane feeds a private FIFO, and a round-robin
// arbiter drains them onto one registered valid/ready output tagged with the lane index.
module submod_rr_merge #(
  parameter  int NUM_CH = 2,
  parameter  int DATA_W = 4,
  parameter  int DEPTH  = 4,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH-1:0]        overflow,
  input  logic                     clear_ovf
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so that full and empty differ.
  logic [DATA_W-1:0] mem    [NUM_CH][DEPTH];
  logic [AW:0]       wr_ptr [NUM_CH];
  logic [AW:0]       rd_ptr [NUM_CH];

  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] drop;

  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   grant;
  logic [CH_W-1:0]   next_ptr;
  logic              found;
  logic              load;
  logic [AW:0]       head_ptr;
  logic [DATA_W-1:0] head_word;

  always_comb begin
    empty = '0;
    full  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      empty[i] = (wr_ptr[i] == rd_ptr[i]);
      full[i]  = (wr_ptr[i] == {~rd_ptr[i][AW], rd_ptr[i][AW-1:0]});
    end
  end

  // First non-empty lane at or after rr_ptr, scanning in wrap-around order.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!found && !empty[(int'(rr_ptr) + k) % NUM_CH]) begin
        found = 1'b1;
        grant = CH_W'((int'(rr_ptr) + k) % NUM_CH);
      end
    end
  end

  assign load      = (!out_valid || out_ready) && found;
  assign next_ptr  = (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
  assign head_ptr  = rd_ptr[grant];
  assign head_word = mem[grant][head_ptr[AW-1:0]];

  // A full lane still accepts a word when it is popped in the same cycle.
  always_comb begin
    pop  = '0;
    push = '0;
    drop = '0;
    if (load) pop[grant] = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      push[i] = in_valid[i] && (!full[i] || pop[i]);
      drop[i] = in_valid[i] && full[i] && !pop[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (push[i]) mem[i][wr_ptr[i][AW-1:0]] <= in_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      rr_ptr    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      overflow  <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
      end
      // A drop in the same cycle as clear_ovf keeps the flag set.
      overflow <= (overflow & ~{NUM_CH{clear_ovf}}) | drop;
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= head_word;
        out_ch    <= grant;
        rr_ptr    <= next_ptr;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_submod_rr_merge.sv
// Scoreboard bench for submod_rr_merge: directed lane traffic, expected words
// queued at stimulus time and checked by an independent output monitor.
module tb_submod_rr_merge;

  localparam int NUM_CH = 2;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 4;
  localparam int CH_W   = 1;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_CH*DATA_W-1:0] in_data = '0;
  logic [NUM_CH-1:0]        in_valid = '0;
  logic [DATA_W-1:0]        out_data;
  logic [CH_W-1:0]          out_ch;
  logic                     out_valid;
  logic                     out_ready = 1'b0;
  logic [NUM_CH-1:0]        overflow;
  logic                     clear_ovf = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [CH_W+DATA_W-1:0] exp_q[$];

  submod_rr_merge #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
    .out_ready(out_ready), .overflow(overflow), .clear_ovf(clear_ovf)
  );

  always #5 clk = ~clk;

  // Monitor: a handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_output: got ch=%0d data=%h, expected nothing", out_ch, out_data);
      end else begin
        logic [CH_W+DATA_W-1:0] e;
        e = exp_q.pop_front();
        if ({out_ch, out_data} !== e) begin
          errors++;
          $display("[TB] FAIL scoreboard: got ch=%0d data=%h, expected ch=%0d data=%h",
                   out_ch, out_data, e[DATA_W], e[DATA_W-1:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] v, input logic [3:0] d1, input logic [3:0] d0,
                               input logic rdy, input logic clr);
    in_valid  = v;
    in_data   = {d1, d0};
    out_ready = rdy;
    clear_ovf = clr;
    tick();
  endtask

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic pushExp(input logic ch, input logic [3:0] d);
    exp_q.push_back({ch, d});
  endtask

  task automatic doReset(input int n);
    rst       = 1'b1;
    out_ready = 1'b0;
    clear_ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_valid = 2'($urandom);
      in_data  = 8'($urandom);
      tick();
    end
    rst      = 1'b0;
    in_valid = '0;
    in_data  = '0;
    exp_q.delete();
  endtask

  task automatic waitDrain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s: %0d words still pending, expected 0", name, exp_q.size());
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_valid"},    8'(out_valid), 8'h0);
    checkOutput({tag, "_data"},     8'(out_data),  8'h0);
    checkOutput({tag, "_ch"},       8'(out_ch),    8'h0);
    checkOutput({tag, "_overflow"}, 8'(overflow),  8'h0);
  endtask

  initial begin
    // Reset with random lane activity; nothing may appear afterwards.
    doReset(2);
    checkResetState("reset");
    for (int i = 0; i < 3; i++) applyStimulus(2'b00, 4'h0, 4'h0, 1'b1, 1'b0);
    checkOutput("idle_valid", 8'(out_valid), 8'h0);

    // Single word on lane 1: visible after the second edge, gone after the third.
    pushExp(1'b1, 4'hA);
    applyStimulus(2'b10, 4'hA, 4'h0, 1'b1, 1'b0);
    checkOutput("lat_not_yet", 8'(out_valid), 8'h0);
    applyStimulus(2'b00, 4'h0, 4'h0, 1'b1, 1'b0);
    checkOutput("lat_valid", 8'(out_valid), 8'h1);
    checkOutput("lat_data",  8'(out_data),  8'h0A);
    checkOutput("lat_ch",    8'(out_ch),    8'h1);
    applyStimulus(2'b00, 4'h0, 4'h0, 1'b1, 1'b0);
    checkOutput("lat_clear", 8'(out_valid), 8'h0);

    // Both lanes active: grants alternate 0,1,0,1... with no drops.
    doReset(1);
    for (int i = 0; i < 6; i++) begin
      pushExp(1'b0, 4'h1);
      pushExp(1'b1, 4'h2);
    end
    for (int i = 0; i < 6; i++) applyStimulus(2'b11, 4'h2, 4'h1, 1'b1, 1'b0);
    applyStimulus(2'b00, 4'h0, 4'h0, 1'b1, 1'b0);
    waitDrain("rr_drain", 30);
    checkOutput("rr_overflow", 8'(overflow), 8'h0);

    // Backpressure: six words into a stalled lane 0, the sixth is dropped.
    doReset(1);
    for (int i = 0; i < 6; i++) applyStimulus(2'b01, 4'h0, 4'(i), 1'b0, 1'b0);
    applyStimulus(2'b00, 4'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("bp_valid",    8'(out_valid), 8'h1);
    checkOutput("bp_data",     8'(out_data),  8'h0);
    checkOutput("bp_overflow", 8'(overflow),  8'h1);
    applyStimulus(2'b00, 4'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("bp_hold", 8'(out_data), 8'h0);
    for (int i = 0; i < 5; i++) pushExp(1'b0, 4'(i));
    applyStimulus(2'b00, 4'h0, 4'h0, 1'b1, 1'b0);
    waitDrain("bp_drain", 20);
    applyStimulus(2'b00, 4'h0, 4'h0, 1'b1, 1'b0);
    checkOutput("bp_idle", 8'(out_valid), 8'h0);
    applyStimulus(2'b00, 4'h0, 4'h0, 1'b1, 1'b1);
    checkOutput("bp_cleared", 8'(overflow), 8'h0);

    // Push into a full lane in the same cycle it is popped.
    doReset(1);
    applyStimulus(2'b01, 4'h0, 4'h8, 1'b0, 1'b0);
    applyStimulus(2'b01, 4'h0, 4'h9, 1'b0, 1'b0);
    applyStimulus(2'b01, 4'h0, 4'hA, 1'b0, 1'b0);
    applyStimulus(2'b01, 4'h0, 4'hB, 1'b0, 1'b0);
    applyStimulus(2'b01, 4'h0, 4'hC, 1'b0, 1'b0);
    pushExp(1'b0, 4'h8); pushExp(1'b0, 4'h9); pushExp(1'b0, 4'hA);
    pushExp(1'b0, 4'hB); pushExp(1'b0, 4'hC); pushExp(1'b0, 4'h7);
    applyStimulus(2'b01, 4'h0, 4'h7, 1'b1, 1'b0);
    checkOutput("full_pop_overflow", 8'(overflow), 8'h0);
    applyStimulus(2'b00, 4'h0, 4'h0, 1'b1, 1'b0);
    waitDrain("full_pop_drain", 20);

    // Sticky flag: set beats clear, then a lone clear empties it.
    doReset(1);
    for (int i = 0; i < 6; i++) applyStimulus(2'b10, 4'(i), 4'h0, 1'b0, 1'b0);
    checkOutput("ovf_set", 8'(overflow), 8'h2);
    applyStimulus(2'b10, 4'h6, 4'h0, 1'b0, 1'b1);
    checkOutput("ovf_set_wins", 8'(overflow), 8'h2);
    applyStimulus(2'b00, 4'h0, 4'h0, 1'b0, 1'b1);
    checkOutput("ovf_clear", 8'(overflow), 8'h0);
    for (int i = 0; i < 4; i++) applyStimulus(2'b01, 4'h0, 4'(i + 3), 1'b0, 1'b0);
    applyStimulus(2'b00, 4'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("filled_valid", 8'(out_valid), 8'h1);

    // Mid-operation reset discards everything buffered.
    doReset(1);
    checkResetState("midrst");
    for (int i = 0; i < 8; i++) applyStimulus(2'b00, 4'h0, 4'h0, 1'b1, 1'b0);
    checkOutput("midrst_idle", 8'(out_valid), 8'h0);
    checkOutput("scoreboard_empty", 8'(exp_q.size()), 8'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
